// File: rtl/lrf_fuse_sequencer.sv
// lrf_fuse_sequencer
//   Control-plane sequencer for the LRF multi-frame fusion datapath. Owns the
//   AXI-Stream handshake, generates the datapath step enable, tracks the beat
//   and frame position inside a fusion group, drives the running-average
//   buffer opcodes and carries a {valid,last} token alongside the datapath so
//   only the fused output frame is marked valid. Each group end drains the
//   pipeline (FLUSH) before new input is accepted.
//
// Ports
//   s_axis_aclk / s_axis_areset : clock, async active-high reset
//   s_axis_tvalid/tready/tlast  : input stream handshake (tlast is checked only)
//   m_axis_tready/tvalid/tlast  : fused output stream handshake
//   step                        : datapath advance enable (combinational)
//   beat_idx, frame_idx         : position of the current input beat
//   first_frame                 : frame_idx == 0
//   avg_load, avg_sub           : running-average buffer opcodes
//   tlast_err                   : sticky upstream framing mismatch
//   busy                        : sequencer not idle
module lrf_fuse_sequencer #(
  parameter int PIXELS_PER_BEAT  = 16,
  parameter int IMAGE_DIM        = 512,
  parameter int N_FUSE_COUNT     = 4,
  parameter int PIPELINE_DELAY   = 21,
  localparam int BEATS_PER_IMAGE = IMAGE_DIM*IMAGE_DIM/PIXELS_PER_BEAT,
  localparam int NB              = $clog2(BEATS_PER_IMAGE)
) (
  input  logic                    s_axis_aclk,
  input  logic                    s_axis_areset,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic                    s_axis_tlast,
  input  logic                    m_axis_tready,
  output logic                    m_axis_tvalid,
  output logic                    m_axis_tlast,
  output logic                    step,
  output logic [NB-1:0]           beat_idx,
  output logic [N_FUSE_COUNT-1:0] frame_idx,
  output logic                    first_frame,
  output logic                    avg_load,
  output logic                    avg_sub,
  output logic                    tlast_err,
  output logic                    busy
);

  localparam int FUSE_COUNT = 1 << N_FUSE_COUNT;
  localparam int FW         = $clog2(PIPELINE_DELAY + 1);
  localparam logic [NB-1:0]           LAST_BEAT  = NB'(BEATS_PER_IMAGE - 1);
  localparam logic [N_FUSE_COUNT-1:0] LAST_FRAME = N_FUSE_COUNT'(FUSE_COUNT - 1);
  localparam logic [FW-1:0]           FLUSH_LAST = FW'(PIPELINE_DELAY - 1);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  typedef struct packed {
    logic v;
    logic l;
  } tok_t;

  state_t                   r_state, w_state_nxt;
  logic [NB-1:0]            r_beat;
  logic [N_FUSE_COUNT-1:0]  r_frame;
  logic                     r_avg_load, r_avg_sub, r_tlast_err;
  logic [FW-1:0]            r_flush_cnt;
  tok_t [PIPELINE_DELAY-1:0] r_pipe;

  logic w_accept, w_beat_wrap, w_frame_last;
  tok_t w_head;

  assign w_beat_wrap  = (r_beat == LAST_BEAT);
  assign w_frame_last = (r_frame == LAST_FRAME);

  // Handshake, step and next state. In FLUSH the datapath keeps stepping on
  // downstream ready alone so the last fused beats drain out.
  always_comb begin
    s_axis_tready = 1'b0;
    step          = 1'b0;
    w_accept      = 1'b0;
    w_state_nxt   = r_state;
    w_head        = '0;
    case (r_state)
      IDLE, RUN: begin
        s_axis_tready = m_axis_tready;
        step          = s_axis_tvalid & m_axis_tready;
        w_accept      = step;
        if (w_accept)
          w_state_nxt = (w_beat_wrap && w_frame_last) ? FLUSH : RUN;
      end
      FLUSH: begin
        step = m_axis_tready;
        if (step && r_flush_cnt == FLUSH_LAST)
          w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
    // Only beats of the last group frame produce a fused output; FLUSH shifts zeros.
    w_head.v = w_accept & w_frame_last;
    w_head.l = w_accept & w_frame_last & w_beat_wrap;
  end

  always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
    if (s_axis_areset) begin
      r_state     <= IDLE;
      r_beat      <= '0;
      r_frame     <= '0;
      r_avg_load  <= 1'b1;
      r_avg_sub   <= 1'b1;
      r_tlast_err <= 1'b0;
      r_flush_cnt <= '0;
      r_pipe      <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        if (s_axis_tlast != w_beat_wrap)
          r_tlast_err <= 1'b1;
        if (w_beat_wrap) begin
          r_beat     <= '0;
          r_frame    <= w_frame_last ? '0 : r_frame + 1'b1;
          r_avg_load <= 1'b0;
          r_avg_sub  <= ~r_avg_sub;
        end else begin
          r_beat <= r_beat + 1'b1;
        end
      end
      if (r_state == FLUSH && step)
        r_flush_cnt <= (r_flush_cnt == FLUSH_LAST) ? '0 : r_flush_cnt + 1'b1;
      // Token pipe moves in lockstep with the datapath; no step means hold.
      if (step) begin
        r_pipe[0] <= w_head;
        for (int i = 1; i < PIPELINE_DELAY; i++)
          r_pipe[i] <= r_pipe[i-1];
      end
    end
  end

  assign m_axis_tvalid = r_pipe[PIPELINE_DELAY-1].v;
  assign m_axis_tlast  = r_pipe[PIPELINE_DELAY-1].l;
  assign beat_idx      = r_beat;
  assign frame_idx     = r_frame;
  assign first_frame   = (r_frame == '0);
  assign avg_load      = r_avg_load;
  assign avg_sub       = r_avg_sub;
  assign tlast_err     = r_tlast_err;
  assign busy          = (r_state != IDLE);

endmodule

// File: tb/tb_lrf_fuse_sequencer.sv
module tb_lrf_fuse_sequencer;
  localparam int PPB = 4, DIM = 8, NF = 2, PD = 3;
  localparam int BPI = DIM*DIM/PPB;   // 16 beats per frame
  localparam int GRP = BPI * (1 << NF); // 64 beats per group
  localparam int NB  = 4;

  logic clk = 1'b0, rst = 1'b1;
  logic s_tvalid = 1'b0, s_tlast = 1'b0, m_tready = 1'b1;
  logic s_tready, m_tvalid, m_tlast, step, first_frame, avg_load, avg_sub, tlast_err, busy;
  logic [NB-1:0] beat_idx;
  logic [NF-1:0] frame_idx;

  int n_tests = 0, n_fail = 0, cyc = 0;

  // scoreboard: expected tlast of each fused output beat, in order
  logic q[$];
  logic [3:0] mb;
  logic [1:0] mf;
  logic ml, ms, exp_l;

  lrf_fuse_sequencer #(
    .PIXELS_PER_BEAT(PPB), .IMAGE_DIM(DIM), .N_FUSE_COUNT(NF), .PIPELINE_DELAY(PD)
  ) dut (
    .s_axis_aclk(clk), .s_axis_areset(rst),
    .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .s_axis_tlast(s_tlast),
    .m_axis_tready(m_tready), .m_axis_tvalid(m_tvalid), .m_axis_tlast(m_tlast),
    .step(step), .beat_idx(beat_idx), .frame_idx(frame_idx), .first_frame(first_frame),
    .avg_load(avg_load), .avg_sub(avg_sub), .tlast_err(tlast_err), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

  // Scoreboard monitor: reference counters advance on each input handshake,
  // expected output tokens are pushed then, and popped on output handshakes.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      mb = '0; mf = '0; ml = 1'b1; ms = 1'b1;
    end else begin
      if (m_tvalid && m_tready) begin
        n_tests++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL out_unexpected cyc=%0d: output beat with tlast=%b, none expected", cyc, m_tlast);
        end else begin
          exp_l = q.pop_front();
          if (m_tlast !== exp_l || step !== 1'b1) begin
            n_fail++;
            $display("FAIL out_beat cyc=%0d: tlast=%b step=%b, want tlast=%b step=1", cyc, m_tlast, step, exp_l);
          end
        end
      end
      if (s_tvalid && s_tready) begin
        n_tests++;
        if ({beat_idx, frame_idx, avg_load, avg_sub, first_frame} !== {mb, mf, ml, ms, (mf == 2'd0)}) begin
          n_fail++;
          $display("FAIL in_ctrl cyc=%0d: beat=%0d frame=%0d load=%b sub=%b first=%b, want %0d %0d %b %b %b",
                   cyc, beat_idx, frame_idx, avg_load, avg_sub, first_frame, mb, mf, ml, ms, (mf == 2'd0));
        end
        if (mf == 2'd3) q.push_back(mb == 4'd15);
        if (mb == 4'd15) begin
          mb = '0; mf = mf + 2'd1; ml = 1'b0; ms = ~ms;
        end else begin
          mb = mb + 4'd1;
        end
      end
    end
  end

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; s_tvalid = 1'b0; s_tlast = 1'b0; m_tready = 1'b1;
    repeat (2) @(posedge clk);
    #3;
    n_tests++;
    if ({m_tvalid, m_tlast, busy, tlast_err} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_outs: tvalid=%b tlast=%b busy=%b err=%b, want 0000", m_tvalid, m_tlast, busy, tlast_err);
    end
    n_tests++;
    if (beat_idx !== 4'd0 || frame_idx !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_counters: beat=%0d frame=%0d, want 0 0", beat_idx, frame_idx);
    end
    n_tests++;
    if ({avg_load, avg_sub, first_frame} !== 3'b111) begin
      n_fail++;
      $display("FAIL reset_avg: load=%b sub=%b first=%b, want 111", avg_load, avg_sub, first_frame);
    end
    n_tests++;
    if (s_tready !== 1'b1 || step !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle_hs: s_tready=%b step=%b, want 1 0", s_tready, step);
    end
    rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if (busy !== 1'b0 || m_tvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_idle: busy=%b tvalid=%b, want 0 0", busy, m_tvalid);
    end
    next_cycle();
  endtask

  task automatic test_continuous;
    int acc = 0, c48 = -1, cend = -1, cfirst = -1, nv = 0, nl = 0, lastn = 0, nfl = 0;
    m_tready = 1'b1;
    for (int k = 0; k < 80; k++) begin
      s_tvalid = (acc < GRP);
      s_tlast  = (acc % BPI == BPI - 1);
      @(negedge clk);
      if (cend >= 0 && cyc > cend && cyc <= cend + PD) begin
        n_tests++;
        if (s_tready !== 1'b0 || busy !== 1'b1 || step !== 1'b1) begin
          n_fail++;
          $display("FAIL flush_cycle cyc=%0d: s_tready=%b busy=%b step=%b, want 0 1 1", cyc, s_tready, busy, step);
        end else nfl++;
      end
      if (cend >= 0 && cyc == cend + PD + 1) begin
        n_tests++;
        if (busy !== 1'b0 || s_tready !== 1'b1) begin
          n_fail++;
          $display("FAIL flush_to_idle: busy=%b s_tready=%b, want 0 1", busy, s_tready);
        end
      end
      if (m_tvalid) begin
        if (cfirst < 0) cfirst = cyc;
        nv++;
        if (m_tlast) begin nl++; lastn = nv; end
      end
      if (s_tvalid && s_tready) begin
        if (acc == 48) c48 = cyc;
        if (acc == GRP - 1) cend = cyc;
        acc++;
      end
      next_cycle();
    end
    s_tvalid = 1'b0; s_tlast = 1'b0;
    n_tests++;
    if (c48 < 0 || cfirst != c48 + PD) begin
      n_fail++;
      $display("FAIL cont_latency: first output cyc=%0d, want %0d", cfirst, c48 + PD);
    end
    n_tests++;
    if (nv != BPI || nl != 1 || lastn != BPI) begin
      n_fail++;
      $display("FAIL cont_outputs: valid=%0d tlasts=%0d tlast_on=%0d, want 16 1 16", nv, nl, lastn);
    end
    n_tests++;
    if (nfl != PD) begin
      n_fail++;
      $display("FAIL cont_flush_len: %0d good flush cycles, want %0d", nfl, PD);
    end
  endtask

  task automatic test_backpressure;
    int acc = 0, nout = 0, nl = 0, hold = 0;
    bit done = 1'b0;
    logic [NB-1:0] bi = '0;
    for (int k = 0; k < 100; k++) begin
      s_tvalid = (acc < GRP);
      s_tlast  = (acc % BPI == BPI - 1);
      m_tready = (hold == 0);
      @(negedge clk);
      if (hold > 0) begin
        if (hold == 5) bi = beat_idx;
        n_tests++;
        if (step !== 1'b0 || m_tvalid !== 1'b1 || m_tlast !== 1'b0 || beat_idx !== bi || s_tready !== 1'b0) begin
          n_fail++;
          $display("FAIL stall_hold cyc=%0d: step=%b tvalid=%b tlast=%b beat=%0d s_tready=%b, want 0 1 0 %0d 0",
                   cyc, step, m_tvalid, m_tlast, beat_idx, s_tready, bi);
        end
        hold--;
      end
      if (m_tvalid && m_tready) begin
        nout++;
        if (m_tlast) nl++;
        if (nout == 7 && !done) begin hold = 5; done = 1'b1; end
      end
      if (s_tvalid && s_tready) acc++;
      next_cycle();
    end
    s_tvalid = 1'b0; s_tlast = 1'b0; m_tready = 1'b1;
    n_tests++;
    if (nout != BPI || nl != 1 || !done || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_outputs: outs=%0d tlasts=%0d stalled=%b busy=%b, want 16 1 1 0", nout, nl, done, busy);
    end
  endtask

  task automatic test_gaps;
    int acc = 0, nout = 0, nl = 0, bad_gap = 0;
    m_tready = 1'b1;
    for (int k = 0; k < 140; k++) begin
      s_tvalid = (acc < 48) ? (k % 2 == 0) : (acc < GRP);
      s_tlast  = (acc % BPI == BPI - 1);
      @(negedge clk);
      if (!s_tvalid && acc < 48) begin
        n_tests++;
        if (step !== 1'b0) begin
          n_fail++; bad_gap++;
          $display("FAIL gap_step cyc=%0d: step=%b, want 0", cyc, step);
        end
      end
      if (m_tvalid && m_tready) begin nout++; if (m_tlast) nl++; end
      if (s_tvalid && s_tready) acc++;
      next_cycle();
    end
    s_tvalid = 1'b0; s_tlast = 1'b0;
    n_tests++;
    if (nout != BPI || nl != 1 || acc != GRP) begin
      n_fail++;
      $display("FAIL gap_outputs: outs=%0d tlasts=%0d accepted=%0d, want 16 1 64", nout, nl, acc);
    end
  endtask

  task automatic test_back_to_back;
    int acc = 0, nout = 0, nl = 0, loads = 0;
    m_tready = 1'b1;
    for (int k = 0; k < 160; k++) begin
      s_tvalid = (acc < 2*GRP);
      s_tlast  = (acc % BPI == BPI - 1);
      @(negedge clk);
      if (m_tvalid && m_tready) begin nout++; if (m_tlast) nl++; end
      if (s_tvalid && s_tready) begin
        if (avg_load) loads++;
        acc++;
      end
      next_cycle();
    end
    s_tvalid = 1'b0; s_tlast = 1'b0;
    n_tests++;
    if (nout != 2*BPI || nl != 2 || acc != 2*GRP) begin
      n_fail++;
      $display("FAIL b2b_outputs: outs=%0d tlasts=%0d accepted=%0d, want 32 2 128", nout, nl, acc);
    end
    n_tests++;
    if (loads != 0) begin
      n_fail++;
      $display("FAIL b2b_avg_load: %0d beats with avg_load=1, want 0", loads);
    end
  endtask

  task automatic test_tlast_err;
    int acc = 0;
    m_tready = 1'b1;
    for (int k = 0; k < 80; k++) begin
      s_tvalid = (acc < GRP);
      s_tlast  = (acc % BPI == BPI - 1) || (acc == 9);
      @(negedge clk);
      if (acc == 9 && s_tvalid) begin
        n_tests++;
        if (tlast_err !== 1'b0) begin
          n_fail++;
          $display("FAIL tlast_err_early: err=%b before bad beat, want 0", tlast_err);
        end
      end
      if (acc == 16 && s_tvalid) begin
        n_tests++;
        if (beat_idx !== 4'd0 || frame_idx !== 2'd1 || tlast_err !== 1'b1) begin
          n_fail++;
          $display("FAIL tlast_frame_wrap: beat=%0d frame=%0d err=%b, want 0 1 1", beat_idx, frame_idx, tlast_err);
        end
      end
      if (s_tvalid && s_tready) acc++;
      next_cycle();
    end
    s_tvalid = 1'b0; s_tlast = 1'b0;
    n_tests++;
    if (tlast_err !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL tlast_err_sticky: err=%b busy=%b, want 1 0", tlast_err, busy);
    end
  endtask

  task automatic test_reset_flush;
    int acc = 0, cend = -1, k = 0, c48 = -1, cfirst = -1, nv = 0, nl = 0, early = 0;
    m_tready = 1'b1;
    while (k < 100 && !(cend >= 0 && cyc == cend + 2)) begin
      s_tvalid = (acc < GRP);
      s_tlast  = (acc % BPI == BPI - 1);
      @(negedge clk);
      if (s_tvalid && s_tready) begin
        if (acc == GRP - 1) cend = cyc;
        acc++;
      end
      next_cycle();
      k++;
    end
    s_tvalid = 1'b0; s_tlast = 1'b0;
    n_tests++;
    if (busy !== 1'b1 || m_tvalid !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset_flush: busy=%b tvalid=%b, want 1 1", busy, m_tvalid);
    end
    #1 rst = 1'b1;
    #1;
    n_tests++;
    if ({m_tvalid, m_tlast, busy, tlast_err} !== 4'b0000) begin
      n_fail++;
      $display("FAIL async_reset_outs: tvalid=%b tlast=%b busy=%b err=%b, want 0000", m_tvalid, m_tlast, busy, tlast_err);
    end
    n_tests++;
    if (avg_load !== 1'b1 || frame_idx !== 2'd0 || beat_idx !== 4'd0) begin
      n_fail++;
      $display("FAIL async_reset_ctrl: load=%b frame=%0d beat=%0d, want 1 0 0", avg_load, frame_idx, beat_idx);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    acc = 0;
    for (int j = 0; j < 90; j++) begin
      s_tvalid = (acc < GRP);
      s_tlast  = (acc % BPI == BPI - 1);
      @(negedge clk);
      if (m_tvalid) begin
        if (c48 < 0 || cyc < c48 + PD) early++;
        if (cfirst < 0) cfirst = cyc;
        nv++;
        if (m_tlast) nl++;
      end
      if (s_tvalid && s_tready) begin
        if (acc == 48) c48 = cyc;
        acc++;
      end
      next_cycle();
    end
    s_tvalid = 1'b0; s_tlast = 1'b0;
    n_tests++;
    if (early != 0 || c48 < 0 || cfirst != c48 + PD) begin
      n_fail++;
      $display("FAIL post_reset_latency: early=%0d first=%0d, want 0 %0d", early, cfirst, c48 + PD);
    end
    n_tests++;
    if (nv != BPI || nl != 1) begin
      n_fail++;
      $display("FAIL post_reset_outputs: valid=%0d tlasts=%0d, want 16 1", nv, nl);
    end
  endtask

  initial begin
    test_reset();
    test_continuous();
    test_backpressure();
    test_gaps();
    test_back_to_back();
    test_tlast_err();
    test_reset_flush();
    repeat (3) next_cycle();
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d expected outputs never seen, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
